// File: rtl/fp32_divider.sv
// Iterative FP32 divider (restoring, one quotient bit per cycle, RNE, denormals flushed).
// Fixed 28-cycle latency from accepted start to done pulse; start is ignored while busy.
module fp32_divider #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [EXP_W+FRAC_W:0]       X,
  input  logic [EXP_W+FRAC_W:0]       Y,
  output logic                        busy,
  output logic                        done,
  output logic [EXP_W+FRAC_W:0]       Result,
  output logic                        inf,
  output logic                        div_by_zero,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int W  = EXP_W + FRAC_W + 1;
  localparam int RW = FRAC_W + 2;
  localparam int QW = FRAC_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0]        LAST_CNT = CW'(QW - 1);
  localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO    = '0;
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM, S_ROUND} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     sign_q, sign_d;
  logic [EXP_W-1:0]         xe_q, xe_d, ye_q, ye_d;
  logic [FRAC_W-1:0]        xf_q, xf_d, yf_q, yf_d;
  logic [RW-1:0]            r_q, r_d;
  logic [QW-1:0]            q_q, q_d;
  logic [FRAC_W-1:0]        nf_q, nf_d;
  logic                     ng_q, ng_d, ns_q, ns_d;
  logic signed [EW-1:0]     ne_q, ne_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [W-1:0]             result_q, result_d;
  logic                     inf_q, inf_d, dbz_q, dbz_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [RW-1:0]            divisor, rem;
  logic                     q_bit;
  logic signed [EW-1:0]     exp_base, e_rnd;
  logic [FRAC_W:0]          frac_sum;
  logic                     round_up;
  logic                     x_zero, y_zero, x_ones, y_ones, x_nan, y_nan, x_inf, y_inf;

  always_comb begin
    divisor  = {1'b0, 1'b1, yf_q};
    q_bit    = (r_q >= divisor);
    rem      = q_bit ? (r_q - divisor) : r_q;
    exp_base = $signed({2'b00, xe_q}) - $signed({2'b00, ye_q}) + $signed(EW'(BIAS));

    round_up = ng_q & (ns_q | nf_q[0]);
    frac_sum = {1'b0, nf_q} + {{FRAC_W{1'b0}}, round_up};
    e_rnd    = ne_q + $signed({{(EW-1){1'b0}}, frac_sum[FRAC_W]});

    x_zero = (xe_q == '0);
    y_zero = (ye_q == '0);
    x_ones = &xe_q;
    y_ones = &ye_q;
    x_nan  = x_ones & (|xf_q);
    y_nan  = y_ones & (|yf_q);
    x_inf  = x_ones & ~(|xf_q);
    y_inf  = y_ones & ~(|yf_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    xf_d     = xf_q;
    yf_d     = yf_q;
    r_d      = r_q;
    q_d      = q_q;
    nf_d     = nf_q;
    ng_d     = ng_q;
    ns_d     = ns_q;
    ne_d     = ne_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    inf_d    = inf_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = X[W-1] ^ Y[W-1];
          xe_d    = X[W-2:FRAC_W];
          ye_d    = Y[W-2:FRAC_W];
          xf_d    = X[FRAC_W-1:0];
          yf_d    = Y[FRAC_W-1:0];
          r_d     = {1'b0, 1'b1, X[FRAC_W-1:0]};
          q_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        r_d = {rem[RW-2:0], 1'b0};
        q_d = {q_q[QW-2:0], q_bit};
        if (cnt_q == LAST_CNT) begin
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NORM: begin
        // Q[QW-1] is the integer bit; a zero there means one extra normalising shift.
        if (q_q[QW-1]) begin
          nf_d = q_q[QW-2:2];
          ng_d = q_q[1];
          ns_d = q_q[0] | (|r_q);
          ne_d = exp_base;
        end else begin
          nf_d = q_q[QW-3:1];
          ng_d = q_q[0];
          ns_d = |r_q;
          ne_d = exp_base - $signed(EW'(1));
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        inf_d = x_ones | y_ones;
        dbz_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (x_nan | y_nan | (x_inf & y_inf) | (x_zero & y_zero)) begin
          result_d = QNAN;
        end else if (x_inf) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (y_inf) begin
          result_d = {sign_q, {(W-1){1'b0}}};
        end else if (y_zero) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          dbz_d    = 1'b1;
        end else if (x_zero) begin
          result_d = {sign_q, {(W-1){1'b0}}};
        end else if (e_rnd >= EMAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
        end else if (e_rnd <= EZERO) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, e_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      xe_q     <= '0;
      ye_q     <= '0;
      xf_q     <= '0;
      yf_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      nf_q     <= '0;
      ng_q     <= 1'b0;
      ns_q     <= 1'b0;
      ne_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      inf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      xf_q     <= xf_d;
      yf_q     <= yf_d;
      r_q      <= r_d;
      q_q      <= q_d;
      nf_q     <= nf_d;
      ng_q     <= ng_d;
      ns_q     <= ns_d;
      ne_q     <= ne_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      inf_q    <= inf_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Result      = result_q;
  assign inf         = inf_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
